// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and a 3-input majority helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// Serial line, oversample strobe and received-frame result bundle for the UART receiver.
interface uart_rx_framed_if #(
  parameter int DBIT = 8
);
  logic            i_rx;
  logic            i_s_tick;
  logic            o_rx_done_tick;
  logic [DBIT-1:0] o_data;
  logic            o_parity_err;
  logic            o_frame_err;
  logic            o_break;

  modport master (
    output i_rx, i_s_tick,
    input  o_rx_done_tick, o_data, o_parity_err, o_frame_err, o_break
  );

  modport slave (
    input  i_rx, i_s_tick,
    output o_rx_done_tick, o_data, o_parity_err, o_frame_err, o_break
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop line synchronizer plus a three-sample majority voter for mid-bit decisions.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_rx,
  input  logic i_sample,
  output logic o_rx_s,
  output logic o_vote_now,
  output logic o_vote
);

  logic [1:0] sync_q, sync_d;
  logic [2:0] samp_q, samp_d;

  always_comb begin
    sync_d = {sync_q[0], i_rx};
    samp_d = samp_q;
    if (i_sample) samp_d = {samp_q[1:0], sync_q[1]};
  end

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_q <= 2'b11;
      samp_q <= '0;
    end else begin
      sync_q <= sync_d;
      samp_q <= samp_d;
    end
  end

  assign o_rx_s     = sync_q[1];
  // Vote including the sample being taken this cycle, for the early start-bit glitch check.
  assign o_vote_now = maj3(samp_q[1], samp_q[0], sync_q[1]);
  assign o_vote     = maj3(samp_q[2], samp_q[1], samp_q[0]);

endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with optional parity, framing-error and break detection.
//   state       | meaning
//   ST_IDLE     | line idle, waiting for rx_s low
//   ST_START    | validating start bit, glitch reject at mid-bit
//   ST_DATA     | shifting DBIT data bits, LSB first
//   ST_PARITY   | sampling the parity bit
//   ST_STOP     | sampling first stop bit, timing the SB_TICK stop period
//   ST_BRK_WAIT | stop bit was low, waiting for the line to return high
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int PARITY  = 0,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input logic             i_clock,
  input logic             i_reset,
  uart_rx_framed_if.slave bus
);

  localparam int TW = $clog2(2 * OVS);
  localparam int NW = $clog2(DBIT + 1);
  localparam logic [TW-1:0] T_S0       = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_S2       = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_BIT_END  = TW'(OVS - 1);
  localparam logic [TW-1:0] T_STOP_END = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  rx_state_e       state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [NW-1:0]   nbit_q, nbit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            par_q, par_d;
  logic            any_hi_q, any_hi_d;
  logic            done_q, done_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            brk_q, brk_d;

  logic rx_s, vote_now, vote, sample, in_frame, brk_v, par_x;

  assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign sample   = bus.i_s_tick && in_frame && (tick_q >= T_S0) && (tick_q <= T_S2);

  uart_rx_sampler u_sampler (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_rx       (bus.i_rx),
    .i_sample   (sample),
    .o_rx_s     (rx_s),
    .o_vote_now (vote_now),
    .o_vote     (vote)
  );

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    nbit_d   = nbit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    any_hi_d = any_hi_q;
    done_d   = 1'b0;
    data_d   = data_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    brk_d    = brk_q;
    brk_v    = 1'b0;
    par_x    = (^shift_q) ^ par_q;
    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: if (bus.i_s_tick) begin
        if (tick_q == T_S2 && vote_now) begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end else if (tick_q == T_BIT_END) begin
          state_d  = ST_DATA;
          tick_d   = '0;
          nbit_d   = '0;
          any_hi_d = 1'b0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DATA: if (bus.i_s_tick) begin
        if (tick_q == T_BIT_END) begin
          tick_d   = '0;
          shift_d  = {vote, shift_q[DBIT-1:1]};
          any_hi_d = any_hi_q | vote;
          if (nbit_q == N_LAST) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else                  nbit_d  = nbit_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_PARITY: if (bus.i_s_tick) begin
        if (tick_q == T_BIT_END) begin
          tick_d   = '0;
          par_d    = vote;
          any_hi_d = any_hi_q | vote;
          state_d  = ST_STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_STOP: if (bus.i_s_tick) begin
        if (tick_q == T_STOP_END) begin
          // Break: every data, parity and stop sample low; data is forced to zero.
          brk_v   = !any_hi_q && !vote;
          done_d  = 1'b1;
          data_d  = brk_v ? '0 : shift_q;
          ferr_d  = !vote;
          brk_d   = brk_v;
          perr_d  = (PARITY == PAR_EVEN) ? par_x : (PARITY == PAR_ODD) ? !par_x : 1'b0;
          tick_d  = '0;
          state_d = vote ? ST_IDLE : ST_BRK_WAIT;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_BRK_WAIT: if (rx_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      nbit_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      any_hi_q <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      nbit_q   <= nbit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      any_hi_q <= any_hi_d;
      done_q   <= done_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      brk_q    <= brk_d;
    end
  end

  assign bus.o_rx_done_tick = done_q;
  assign bus.o_data         = data_q;
  assign bus.o_parity_err   = perr_q;
  assign bus.o_frame_err    = ferr_q;
  assign bus.o_break        = brk_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench: 8N1 receiver and a 7-bit even-parity receiver share one line and tick.
module tb_uart_rx_framed;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic s_tick;
  int   checks = 0;
  int   errors = 0;
  int   done0  = 0;
  int   done1  = 0;
  int   ph     = 0;

  always #5 clk = ~clk;

  uart_rx_framed_if #(.DBIT(8)) bus0 ();
  uart_rx_framed_if #(.DBIT(7)) bus1 ();

  assign bus0.i_rx     = rx;
  assign bus0.i_s_tick = s_tick;
  assign bus1.i_rx     = rx;
  assign bus1.i_s_tick = s_tick;

  uart_rx_framed #(.DBIT(8), .PARITY(PAR_NONE), .OVS(16), .SB_TICK(16)) u_dut0 (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus0)
  );

  uart_rx_framed #(.DBIT(7), .PARITY(PAR_EVEN), .OVS(16), .SB_TICK(16)) u_dut1 (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus1)
  );

  // One-clock tick every 8 clocks, driven away from the active edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      s_tick = (ph == 0);
      ph = (ph == 7) ? 0 : ph + 1;
    end
  end

  // Counts cycles with done high, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (bus0.o_rx_done_tick === 1'b1) done0++;
    if (bus1.o_rx_done_tick === 1'b1) done1++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    rx = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [8:0] bits, input int n, input logic glitch);
    wait_ticks(1);
    drive_bit(1'b0, 16);
    for (int i = 0; i < n; i++) begin
      if (glitch) begin
        drive_bit(bits[i], 8);
        drive_bit(~bits[i], 1);
        drive_bit(bits[i], 7);
      end else begin
        drive_bit(bits[i], 16);
      end
    end
    drive_bit(1'b1, 16);
    wait_ticks(4);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus0.o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus0.o_data); end
    checks++; if (bus0.o_rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus0.o_rx_done_tick); end
    checks++; if (bus0.o_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", bus0.o_parity_err); end
    checks++; if (bus0.o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus0.o_frame_err); end
    checks++; if (bus0.o_break !== 1'b0) begin errors++; $display("FAIL reset_break got %b want 0", bus0.o_break); end
    checks++; if (bus1.o_data !== 7'h00) begin errors++; $display("FAIL reset_data1 got %h want 00", bus1.o_data); end
  endtask

  task automatic test_basic();
    int d0;
    d0 = done0;
    send_frame(9'h0A5, 8, 1'b0);
    checks++; if (done0 - d0 !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", done0 - d0); end
    checks++; if (bus0.o_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", bus0.o_data); end
    checks++; if (bus0.o_parity_err !== 1'b0) begin errors++; $display("FAIL basic_perr got %b want 0", bus0.o_parity_err); end
    checks++; if (bus0.o_frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b want 0", bus0.o_frame_err); end
    checks++; if (bus0.o_break !== 1'b0) begin errors++; $display("FAIL basic_break got %b want 0", bus0.o_break); end
  endtask

  task automatic test_parity();
    int d1;
    d1 = done1;
    // 0x41 has two ones; even parity bit should be 0, sending 1 is an error.
    send_frame(9'h0C1, 8, 1'b0);
    checks++; if (done1 - d1 !== 1) begin errors++; $display("FAIL par_done got %0d want 1", done1 - d1); end
    checks++; if (bus1.o_data !== 7'h41) begin errors++; $display("FAIL par_data got %h want 41", bus1.o_data); end
    checks++; if (bus1.o_parity_err !== 1'b1) begin errors++; $display("FAIL par_err got %b want 1", bus1.o_parity_err); end
    checks++; if (bus1.o_frame_err !== 1'b0) begin errors++; $display("FAIL par_ferr got %b want 0", bus1.o_frame_err); end
    checks++; if (bus0.o_data !== 8'hC1) begin errors++; $display("FAIL par_data0 got %h want c1", bus0.o_data); end
    checks++; if (bus0.o_parity_err !== 1'b0) begin errors++; $display("FAIL par_none_perr got %b want 0", bus0.o_parity_err); end
    send_frame(9'h041, 8, 1'b0);
    checks++; if (bus1.o_parity_err !== 1'b0) begin errors++; $display("FAIL par_ok got %b want 0", bus1.o_parity_err); end
    checks++; if (bus0.o_data !== 8'h41) begin errors++; $display("FAIL par_ok_data0 got %h want 41", bus0.o_data); end
  endtask

  task automatic test_short_start();
    int d0;
    d0 = done0;
    wait_ticks(1);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 48);
    @(negedge clk);
    checks++; if (done0 - d0 !== 0) begin errors++; $display("FAIL glitch_start_done got %0d want 0", done0 - d0); end
    checks++; if (bus0.o_data !== 8'h41) begin errors++; $display("FAIL glitch_start_hold got %h want 41", bus0.o_data); end
    send_frame(9'h03C, 8, 1'b0);
    checks++; if (done0 - d0 !== 1) begin errors++; $display("FAIL after_glitch_done got %0d want 1", done0 - d0); end
    checks++; if (bus0.o_data !== 8'h3C) begin errors++; $display("FAIL after_glitch_data got %h want 3c", bus0.o_data); end
  endtask

  task automatic test_break();
    int d0;
    d0 = done0;
    wait_ticks(1);
    drive_bit(1'b0, 320);
    @(negedge clk);
    checks++; if (done0 - d0 !== 1) begin errors++; $display("FAIL break_done got %0d want 1", done0 - d0); end
    checks++; if (bus0.o_break !== 1'b1) begin errors++; $display("FAIL break_flag got %b want 1", bus0.o_break); end
    checks++; if (bus0.o_frame_err !== 1'b1) begin errors++; $display("FAIL break_ferr got %b want 1", bus0.o_frame_err); end
    checks++; if (bus0.o_data !== 8'h00) begin errors++; $display("FAIL break_data got %h want 00", bus0.o_data); end
    drive_bit(1'b1, 32);
    @(negedge clk);
    checks++; if (done0 - d0 !== 1) begin errors++; $display("FAIL break_release_done got %0d want 1", done0 - d0); end
    send_frame(9'h055, 8, 1'b0);
    checks++; if (bus0.o_data !== 8'h55) begin errors++; $display("FAIL post_break_data got %h want 55", bus0.o_data); end
    checks++; if (bus0.o_break !== 1'b0) begin errors++; $display("FAIL post_break_flag got %b want 0", bus0.o_break); end
    checks++; if (bus0.o_frame_err !== 1'b0) begin errors++; $display("FAIL post_break_ferr got %b want 0", bus0.o_frame_err); end
  endtask

  task automatic test_glitch_vote();
    int d0;
    d0 = done0;
    send_frame(9'h0FF, 8, 1'b1);
    checks++; if (done0 - d0 !== 1) begin errors++; $display("FAIL vote_done got %0d want 1", done0 - d0); end
    checks++; if (bus0.o_data !== 8'hFF) begin errors++; $display("FAIL vote_data got %h want ff", bus0.o_data); end
    checks++; if (bus0.o_frame_err !== 1'b0) begin errors++; $display("FAIL vote_ferr got %b want 0", bus0.o_frame_err); end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done0;
    wait_ticks(1);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 8);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ticks(64);
    @(negedge clk);
    checks++; if (done0 - d0 !== 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", done0 - d0); end
    checks++; if (bus0.o_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", bus0.o_data); end
    checks++; if (bus0.o_frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_ferr got %b want 0", bus0.o_frame_err); end
    checks++; if (bus1.o_parity_err !== 1'b0) begin errors++; $display("FAIL rst_mid_perr1 got %b want 0", bus1.o_parity_err); end
    send_frame(9'h012, 8, 1'b0);
    checks++; if (done0 - d0 !== 1) begin errors++; $display("FAIL rst_next_done got %0d want 1", done0 - d0); end
    checks++; if (bus0.o_data !== 8'h12) begin errors++; $display("FAIL rst_next_data got %h want 12", bus0.o_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_short_start();
    test_break();
    test_glitch_vote();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
